// File: rtl/orv64_regfile_fwd.sv
// Purpose : multi-port integer register file between ID (reads) and WB (writes), with an
//           optional hardwired zero entry, write-to-read forwarding, deterministic write
//           priority with a conflict flag, and a post-reset clearing sweep.
// Latency : read data is one cycle after ra (ra is registered, rd is combinational from it);
//           writes land at the next posedge. wr_conflict is registered.
// Backpressure: none. busy is high during the sweep; writes are then ignored and rd is 0.
// Ports   : clk, rst (sync, active-high); re/ra -> rd per read port; we/wa/wd per write port;
//           busy (sweep in progress); wr_conflict (previous cycle had a same-address write pair).
module orv64_regfile_fwd #(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 32,
    parameter int N_READ_PORT  = 2,
    parameter int N_WRITE_PORT = 2,
    parameter int AW           = $clog2(DEPTH),
    parameter int ZERO_REG     = 1,
    parameter int BYPASS       = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_READ_PORT:1]                re,
    input  logic [N_READ_PORT:1][AW-1:0]        ra,
    output logic [N_READ_PORT:1][WIDTH-1:0]     rd,
    input  logic [N_WRITE_PORT:1]               we,
    input  logic [N_WRITE_PORT:1][AW-1:0]       wa,
    input  logic [N_WRITE_PORT:1][WIDTH-1:0]    wd,
    output logic                                busy,
    output logic                                wr_conflict
);

    typedef enum logic {CLEAR, READY} state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RST != 0) ? CLEAR : READY;

    state_t                          state;
    state_t                          state_nxt;
    logic [AW-1:0]                   idx;
    logic [AW-1:0]                   idx_nxt;
    logic [N_READ_PORT:1][AW-1:0]    ra_ff;
    logic [WIDTH-1:0]                mem [DEPTH];
    logic [N_WRITE_PORT:1]           wr_ok;
    logic                            conflict_nxt;

    // Widen before comparing so a power-of-two DEPTH does not produce a constant compare.
    function automatic logic in_range(input logic [AW-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // ---------------- clearing sweep FSM ----------------
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        if (state == CLEAR) begin
            idx_nxt = idx + 1'b1;
            if (32'(idx) == DEPTH - 1) begin
                state_nxt = READY;
                idx_nxt   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RST_STATE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    assign busy = (state == CLEAR);

    // ---------------- write path ----------------
    always_comb begin
        wr_ok = '0;
        for (int j = 1; j <= N_WRITE_PORT; j++) begin
            wr_ok[j] = we[j] && in_range(wa[j]) && !is_zero_reg(wa[j]);
        end
    end

    // Address 0 still counts toward a conflict even though those writes are dropped.
    always_comb begin
        conflict_nxt = 1'b0;
        if (!busy) begin
            for (int j = 1; j <= N_WRITE_PORT; j++) begin
                for (int k = j + 1; k <= N_WRITE_PORT; k++) begin
                    if (we[j] && we[k] && (wa[j] == wa[k])) begin
                        conflict_nxt = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= conflict_nxt;
        end
    end

    // Array has no reset of its own; the sweep does the clearing. Ports are visited in
    // ascending order so the last non-blocking write (highest index) wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (busy) begin
                mem[idx] <= '0;
            end else begin
                for (int j = 1; j <= N_WRITE_PORT; j++) begin
                    if (wr_ok[j]) begin
                        mem[wa[j]] <= wd[j];
                    end
                end
            end
        end
    end

    // ---------------- read path ----------------
    // Capture continues during the sweep so the address is ready when busy drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            ra_ff <= '0;
        end else begin
            for (int i = 1; i <= N_READ_PORT; i++) begin
                if (re[i]) begin
                    ra_ff[i] <= ra[i];
                end
            end
        end
    end

    // rd depends only on ra_ff and the write ports, never on re.
    always_comb begin
        rd = '0;
        for (int i = 1; i <= N_READ_PORT; i++) begin
            if (!busy && !rst && in_range(ra_ff[i]) && !is_zero_reg(ra_ff[i])) begin
                rd[i] = mem[ra_ff[i]];
                if (BYPASS != 0) begin
                    for (int j = 1; j <= N_WRITE_PORT; j++) begin
                        if (we[j] && (wa[j] == ra_ff[i])) begin
                            rd[i] = wd[j];
                        end
                    end
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        assert ((1 << AW) >= DEPTH)
            else $fatal(1, "orv64_regfile_fwd: AW too small for DEPTH");
        if (!rst) begin
            assert (!$isunknown(re)) else $error("orv64_regfile_fwd: re has X");
            assert (!$isunknown(we)) else $error("orv64_regfile_fwd: we has X");
            for (int i = 1; i <= N_READ_PORT; i++) begin
                if (re[i]) begin
                    assert (!$isunknown(ra[i])) else $error("orv64_regfile_fwd: ra has X");
                end
            end
            for (int j = 1; j <= N_WRITE_PORT; j++) begin
                if (we[j]) begin
                    assert (!$isunknown(wa[j])) else $error("orv64_regfile_fwd: wa has X");
                end
            end
        end
    end
`endif

endmodule

// File: doc/orv64_regfile_fwd.md
Name: orv64_regfile_fwd

Overview:
Parametrised multi-port integer register file and the successor to the current ORV64 regfile. It adds the following over the current block:
- configurable hardwired-zero entry
- write-to-read forwarding on the registered read address
- deterministic write-port priority with a conflict flag
- a post-reset clearing sweep with a busy indication

It sits between ID (read ports) and WB (write ports) of the orv64 pipeline.

Parameters:
WIDTH, 64, data bits per entry
DEPTH, 32, number of entries (>=2)
N_READ_PORT, 2, read ports, indexed 1..N_READ_PORT
N_WRITE_PORT, 2, write ports, indexed 1..N_WRITE_PORT
AW, $clog2(DEPTH), address width
ZERO_REG, 1, 1: entry 0 always reads 0 and writes to it are dropped
BYPASS, 1, 1: same-cycle write data is forwarded to matching read ports
CLEAR_ON_RST, 1, 1: zero every entry in a sweep after reset release

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
re  input  [N_READ_PORT:1]  read enable; captures ra at posedge
ra  input  [N_READ_PORT:1][AW-1:0]  read address
rd  output  [N_READ_PORT:1][WIDTH-1:0]  read data
we  input  [N_WRITE_PORT:1]  write enable
wa  input  [N_WRITE_PORT:1][AW-1:0]  write address
wd  input  [N_WRITE_PORT:1][WIDTH-1:0]  write data
busy  output  1  clearing sweep in progress; writes ignored, rd forced 0
wr_conflict  output  1  registered pulse: previous cycle had >=2 enabled writes to one address

Behaviour:
- Single clock domain. Reset is synchronous and active-high, on clk/rst as in the rest of the codebase.

Reset:
- While rst=1:
  - ra_ff <= 0, wr_conflict <= 0, sweep index <= 0.
  - FSM <= CLEAR if CLEAR_ON_RST, else READY.
  - busy = 1 if CLEAR_ON_RST, else 0. rd = 0.
- Array contents are not reset directly.

FSM (states CLEAR, READY):
- CLEAR, rst=0: each posedge writes 0 to entry idx and increments idx.
- The posedge with idx==DEPTH-1 moves the FSM to READY. busy is 1 in CLEAR and 0 in READY.
- busy therefore stays high for exactly DEPTH cycles after rst falls.
- rst asserted mid-sweep restarts the sweep from idx 0.
- READY is left only by rst.

Write (READY only):
- At posedge, for each port j with we[j]=1, entry wa[j] <= wd[j].
- If several enabled ports share an address, the highest-indexed port wins.
- wa >= DEPTH is dropped.
- ZERO_REG=1: writes to address 0 are dropped.
- In CLEAR, all we are ignored and never reach the array.

Write conflict:
- wr_conflict <= 1 at the next posedge if any two enabled ports in READY share an address; 0 otherwise.
- Address 0 with ZERO_REG=1 is still counted.

Read:
- ra_ff[i] <= ra[i] at posedge when re[i]=1; held when re[i]=0. Capture also happens during CLEAR.
- rd[i] is combinational from ra_ff[i], giving one-cycle latency from ra.
- rd[i] priority:
  1. busy: 0.
  2. ZERO_REG and ra_ff[i]==0: 0.
  3. BYPASS and some we[j] with wa[j]==ra_ff[i]: wd of the highest such j.
  4. Otherwise regfile[ra_ff[i]].
  5. ra_ff >= DEPTH reads 0.
- BYPASS=0: a write in the same cycle is visible on rd only from the next cycle.
- With re held low, rd tracks later writes to the held address.

Other rules:
- No combinational path from re to rd.
- Read ports are fully independent of each other.
- Not synthesised (SYNTHESIS undefined only):
  - X-checks on re/we, and on ra/wa when enabled.
  - Fatal if 2**AW < DEPTH.

Test Plan:
1. Clearing sweep: rst high 3 cycles, then low, with DEPTH=32, CLEAR_ON_RST=1 -> busy=1 for exactly 32 cycles after the release. we=1 at wa=5 during the sweep is ignored. After busy falls, a read of any address returns 0.
2. Basic read/write: we[1]=1, wa=3, wd=64'hDEAD_BEEF_0123_4567. Next cycle re[2]=1, ra=3 -> rd[2]=64'hDEAD_BEEF_0123_4567 one cycle after ra is presented.
3. Forwarding: ra_ff[1]=7 holding 64'h11. In the same cycle we[2]=1, wa=7, wd=64'h22 -> rd[1]=64'h22 combinationally in that cycle (BYPASS=1). With BYPASS=0, rd[1]=64'h11 in that cycle and 64'h22 the next.
4. Write conflict: we=2'b11, wa={9,9}, wd={64'hAA (port 2), 64'hBB (port 1)} -> entry 9 = 64'hAA, and wr_conflict=1 for exactly the following cycle. Distinct addresses -> wr_conflict=0.
5. Zero register: we[1]=1, wa=0, wd=64'hFF, then read address 0 -> rd=0; wr_conflict unaffected.
6. Reset mid-sweep: pulse rst at sweep idx 20 -> busy stays high a further 32 cycles after the pulse releases. Entries written before the pulse also read back 0 afterwards.
